add_h_border: RTL and testbench
===============================

# add_h_border

Horizontal border insertion actor for the HEVC multi-flux dataflow. For each flux it reads one block size from `ext_size`, then consumes a size×size block of pixels row by row. Each row is emitted widened by BORDER replicated edge pixels on the left and right. It is the inverse of the horizontal border-removal stage and feeds the interpolation filters that need padded rows.

## Interface
Parameters:
- FLUX, 2: number of independent tagged data fluxes sharing the actor.
- BORDER, 4: pixels added on each side of every row; legal range 1..15.
- DATA_WIDTH_IN_OUT, 18: pixel payload width.
- DATA_WIDTH_EXT, 7: block-size payload width.
- TAG_WIDTH, $clog2(FLUX): flux tag width carried in the MSBs of output words.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- read_port_ext_size  read_interface.actor  FLUX flags, DATA_WIDTH_EXT payload  block size S per flux; dout[DATA_WIDTH_EXT-1:0].
- read_port_in_pel  read_interface.actor  FLUX flags, DATA_WIDTH_IN_OUT payload  inner-block pixels; dout[DATA_WIDTH_IN_OUT-1:0].
- write_port_out_pel  write_interface.actor  FLUX full flags, TAG_WIDTH+DATA_WIDTH_IN_OUT  padded pixels; din = {tag, pixel}.

## Operation
- FIFOs are first-word-fall-through: dout is valid while empty[i]==0, and read[i]=1 pops at the next edge.
- Each flux has a private context: state, size S (7b), cnt_h (7b), cnt_v (7b), and last_pel (18b).
- States:
  - IDLE: if ext_size not empty, read it. S==0 means stay in IDLE with no output. Otherwise latch S, clear counters, go to LEFT.
  - LEFT: needs in_pel not empty and out not full. Emit in_pel.dout without reading it (peek). cnt_h++. When cnt_h==BORDER-1, clear cnt_h and go to MID.
  - MID: needs in_pel not empty and out not full. Read and emit the pixel. cnt_h++. On cnt_h==S-1, store the pixel in last_pel, clear cnt_h, go to RIGHT.
  - RIGHT: needs out not full only. Emit last_pel. cnt_h++. On cnt_h==BORDER-1, clear cnt_h. Then, if cnt_v==S-1, clear cnt_v and go to IDLE; else cnt_v++ and go to LEFT.
- Output per block: S rows of S+2·BORDER words.
- Flux selection: each cycle, the lowest-index flux whose current state's condition holds is chosen as tag. If none qualifies, tag=0 and nothing happens.
- Only the selected flux's read and context may change in a cycle.
- All read[i] and write are 0 for non-selected fluxes and when idle.
- din is don't-care when write=0.

## Timing
- Fully combinational handshake. read, write and din are functions of the FIFO flags and context registers in the same cycle; there is no pipeline register.
- Throughput: one output word per cycle across all fluxes. An IDLE size read costs one cycle with no output.
- Latency: from size available to first output is 2 cycles (size read, then first LEFT word), given pixels present.
- Backpressure: if full[tag] is set in LEFT/MID/RIGHT, that flux holds with no read, no write and no counter change. Other fluxes may proceed that cycle.
- Starvation: if in_pel is empty in LEFT/MID, that flux holds. RIGHT proceeds regardless of in_pel.
- Reset (asynchronous): all contexts go to IDLE, with S, cnt_h, cnt_v and last_pel = 0. While rst=1, all read[i]=0 and write=0.
  - Reset mid-row abandons the partial block.
  - Pixels already popped are lost. Unpopped FIFO contents are untouched.
- Counters never wrap: S≤127, and comparisons use S-1 computed in 7 bits, guarded by S≠0.

## Configuration
- HEVC_BORDER_ZERO_PAD_EN defined:
  - LEFT and RIGHT emit pixel value 0 instead of replicated edges.
  - LEFT no longer requires in_pel non-empty.
  - last_pel is not implemented.
- Not defined: edge replication as described above.

## Structure
- Shared package hevc_border_pkg holds:
  - DATA_WIDTH_IN_OUT and DATA_WIDTH_EXT constants;
  - the state enum {IDLE, LEFT, MID, RIGHT} (2b);
  - the per-flux context struct typedef.
- One natural sub-module, flux_prio_sel: FLUX-wide request vector in, lowest-index tag out plus a valid flag. It is reusable by sibling border actors.

## Test plan
- FLUX=2, BORDER=2, flux0 S=2, pixels 10,11,20,21 → flux0 outputs 10,10,10,11,11,11,20,20,20,21,21,21, all with tag 0, then returns to IDLE.
- Same stimulus with full[0] held high for 3 cycles in the middle of the row → the identical sequence, with no words dropped or duplicated, and counters frozen during the stall.
- Both fluxes loaded with S=1, pixels 5 (flux0) and 7 (flux1) → flux0 completes its 5,5,5,5,5 row first; flux1 is served only in cycles where flux0 is blocked or IDLE.
- ext_size=0 on flux0, followed by S=1 with pixel 9 → the zero is consumed with no output, then a 9×(1+2·BORDER) row is emitted.
- Assert rst asynchronously while flux0 is in MID → read and write drop immediately; after release, a fresh S=1 block produces a correct row.
- With HEVC_BORDER_ZERO_PAD_EN, BORDER=2, S=2, pixels 10,11,20,21 → outputs 0,0,10,11,0,0,0,0,20,21,0,0.

Source files
------------

// File: rtl/add_h_border_pkg.sv
// Shared types for the HEVC horizontal border actors.
// HEVC_BORDER_ZERO_PAD_EN drops last_pel from the per-flux context.
package hevc_border_pkg;

    localparam int DATA_WIDTH_IN_OUT = 18;
    localparam int DATA_WIDTH_EXT    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        MID   = 2'd2,
        RIGHT = 2'd3
    } state_t;

    typedef struct packed {
        state_t                      state;
        logic [DATA_WIDTH_EXT-1:0]   size;
        logic [DATA_WIDTH_EXT-1:0]   cnt_h;
        logic [DATA_WIDTH_EXT-1:0]   cnt_v;
`ifndef HEVC_BORDER_ZERO_PAD_EN
        logic [DATA_WIDTH_IN_OUT-1:0] last_pel;
`endif
    } ctx_t;

    // Index of the last element of an n-long run; callers guarantee n != 0.
    function automatic logic [DATA_WIDTH_EXT-1:0] last_idx(input logic [DATA_WIDTH_EXT-1:0] n);
        return n - 1'b1;
    endfunction

endpackage

// File: rtl/add_h_border_if.sv
// FIFO-side interfaces of the border actors: FLUX-wide read ports and a tagged write port.
// Read: dout[i] is valid while empty[i]==0; read[i]=1 pops at the next edge. Write: din is taken when write=1 and full[tag]==0.
interface read_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 18
);
    logic [FLUX-1:0]         empty;
    logic [FLUX-1:0][DW-1:0] dout;
    logic [FLUX-1:0]         read;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 19
);
    logic [FLUX-1:0] full;
    logic [DW-1:0]   din;
    logic            write;

    modport actor (input full, output din, output write);
    modport fifo  (output full, input din, input write);
endinterface

// File: rtl/add_h_border_flux_prio_sel.sv
// Fixed-priority flux selector: lowest-index asserted request wins.
module flux_prio_sel #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      i_req,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_valid
);

    // Scan from the top so the lowest index overwrites last.
    always_comb begin
        o_tag   = '0;
        o_valid = 1'b0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_tag   = TAG_WIDTH'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_h_border.sv
// Horizontal border insertion: each S-pixel row is widened by BORDER edge pixels per side, per flux.
// Define HEVC_BORDER_ZERO_PAD_EN to pad with zeros instead of replicated edge pixels.
module add_h_border #(
    parameter int FLUX              = 2,
    parameter int BORDER            = 4,
    parameter int DATA_WIDTH_IN_OUT = hevc_border_pkg::DATA_WIDTH_IN_OUT,
    parameter int DATA_WIDTH_EXT    = hevc_border_pkg::DATA_WIDTH_EXT,
    parameter int TAG_WIDTH         = $clog2(FLUX)
) (
    input  logic                                clk,
    input  logic                                rst,
    read_interface.actor                        read_port_ext_size,
    read_interface.actor                        read_port_in_pel,
    write_interface.actor                       write_port_out_pel,
    output hevc_border_pkg::state_t [FLUX-1:0] o_dbg_state
);
    import hevc_border_pkg::*;

    localparam logic [DATA_WIDTH_EXT-1:0] B_LAST = DATA_WIDTH_EXT'(BORDER - 1);

    ctx_t                         r_ctx [FLUX];
    ctx_t                         w_cur;
    ctx_t                         w_nxt;
    logic [FLUX-1:0]              w_req;
    logic [TAG_WIDTH-1:0]         w_tag;
    logic                         w_valid;
    logic                         w_go;
    logic [DATA_WIDTH_IN_OUT-1:0] w_pix_in;
    logic [DATA_WIDTH_IN_OUT-1:0] w_out_pix;

    // A flux may be picked only when everything its current state needs is ready.
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            w_req[i] = 1'b0;
            case (r_ctx[i].state)
                IDLE:  w_req[i] = !read_port_ext_size.empty[i];
`ifdef HEVC_BORDER_ZERO_PAD_EN
                LEFT:  w_req[i] = !write_port_out_pel.full[i];
`else
                LEFT:  w_req[i] = !write_port_out_pel.full[i] && !read_port_in_pel.empty[i];
`endif
                MID:   w_req[i] = !write_port_out_pel.full[i] && !read_port_in_pel.empty[i];
                RIGHT: w_req[i] = !write_port_out_pel.full[i];
                default: w_req[i] = 1'b0;
            endcase
        end
    end

    flux_prio_sel #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_sel (
        .i_req   (w_req),
        .o_tag   (w_tag),
        .o_valid (w_valid)
    );

    assign w_cur    = r_ctx[w_tag];
    assign w_pix_in = read_port_in_pel.dout[w_tag];
    assign w_go     = w_valid && !rst;

    // State register: only the selected flux's context advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                r_ctx[i] <= '0;
            end
        end else if (w_valid) begin
            r_ctx[w_tag] <= w_nxt;
        end
    end

    // Next-state logic for the selected flux.
    always_comb begin
        w_nxt = w_cur;
        case (w_cur.state)
            IDLE: begin
                if (read_port_ext_size.dout[w_tag] != '0) begin
                    w_nxt.size  = read_port_ext_size.dout[w_tag];
                    w_nxt.cnt_h = '0;
                    w_nxt.cnt_v = '0;
                    w_nxt.state = LEFT;
                end
            end
            LEFT: begin
                if (w_cur.cnt_h == B_LAST) begin
                    w_nxt.cnt_h = '0;
                    w_nxt.state = MID;
                end else begin
                    w_nxt.cnt_h = w_cur.cnt_h + 1'b1;
                end
            end
            MID: begin
                if (w_cur.cnt_h == last_idx(w_cur.size)) begin
`ifndef HEVC_BORDER_ZERO_PAD_EN
                    w_nxt.last_pel = w_pix_in;
`endif
                    w_nxt.cnt_h = '0;
                    w_nxt.state = RIGHT;
                end else begin
                    w_nxt.cnt_h = w_cur.cnt_h + 1'b1;
                end
            end
            RIGHT: begin
                if (w_cur.cnt_h == B_LAST) begin
                    w_nxt.cnt_h = '0;
                    if (w_cur.cnt_v == last_idx(w_cur.size)) begin
                        w_nxt.cnt_v = '0;
                        w_nxt.state = IDLE;
                    end else begin
                        w_nxt.cnt_v = w_cur.cnt_v + 1'b1;
                        w_nxt.state = LEFT;
                    end
                end else begin
                    w_nxt.cnt_h = w_cur.cnt_h + 1'b1;
                end
            end
            default: w_nxt = w_cur;
        endcase
    end

    // Output logic: LEFT peeks the pixel without popping it; MID pops it.
    always_comb begin
        read_port_ext_size.read = '0;
        read_port_in_pel.read   = '0;
        write_port_out_pel.write = 1'b0;
        w_out_pix               = '0;
        if (w_go) begin
            case (w_cur.state)
                IDLE: read_port_ext_size.read[w_tag] = 1'b1;
                LEFT: begin
                    write_port_out_pel.write = 1'b1;
`ifndef HEVC_BORDER_ZERO_PAD_EN
                    w_out_pix = w_pix_in;
`endif
                end
                MID: begin
                    read_port_in_pel.read[w_tag] = 1'b1;
                    write_port_out_pel.write     = 1'b1;
                    w_out_pix                    = w_pix_in;
                end
                RIGHT: begin
                    write_port_out_pel.write = 1'b1;
`ifndef HEVC_BORDER_ZERO_PAD_EN
                    w_out_pix = w_cur.last_pel;
`endif
                end
                default: w_out_pix = '0;
            endcase
        end
    end

    assign write_port_out_pel.din = {w_tag, w_out_pix};

    for (genvar g = 0; g < FLUX; g++) begin : g_dbg
        assign o_dbg_state[g] = r_ctx[g].state;
    end

endmodule

// File: tb/tb_add_h_border.sv
// Bench for add_h_border: FWFT FIFO models, per-flux expected queues from the row-padding rule, directed and random phases.
module tb_add_h_border;
    import hevc_border_pkg::*;

    localparam int FLUX   = 2;
    localparam int BORDER = 2;
    localparam int DW     = 18;
    localparam int EW     = 7;
    localparam int TW     = 1;
`ifdef HEVC_BORDER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_interface  #(.FLUX(FLUX), .DW(EW))      ext_if ();
    read_interface  #(.FLUX(FLUX), .DW(DW))      pel_if ();
    write_interface #(.FLUX(FLUX), .DW(TW + DW)) out_if ();
    state_t [FLUX-1:0] dbg_state;

    add_h_border #(
        .FLUX              (FLUX),
        .BORDER            (BORDER),
        .DATA_WIDTH_IN_OUT (DW),
        .DATA_WIDTH_EXT    (EW),
        .TAG_WIDTH         (TW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .read_port_ext_size (ext_if),
        .read_port_in_pel   (pel_if),
        .write_port_out_pel (out_if),
        .o_dbg_state        (dbg_state)
    );

    // ---------------- bench state ----------------
    logic [EW-1:0] ext_q   [FLUX][$];
    logic [DW-1:0] pel_q   [FLUX][$];
    logic [DW-1:0] pend_q  [FLUX][$];
    logic [DW-1:0] exp_q   [FLUX][$];
    logic [DW-1:0] out_log [FLUX][$];
    int            tag_log [$];
    logic [FLUX-1:0] full_v = '0;
    bit   trickle   = 1'b0;
    bit   full_rand = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   neg_cyc = 0;
    int   first_wr_cyc = -1;
    int   ext_rd_cyc = -1;
    logic [FLUX-1:0]    s_rd_ext, s_rd_pel;
    logic               s_wr;
    logic [TW+DW-1:0]   s_din;
    logic               rst_edge;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_fifos();
        for (int f = 0; f < FLUX; f++) begin
            ext_if.empty[f] = (ext_q[f].size() == 0);
            ext_if.dout[f]  = (ext_q[f].size() != 0) ? ext_q[f][0] : '0;
            pel_if.empty[f] = (pel_q[f].size() == 0);
            pel_if.dout[f]  = (pel_q[f].size() != 0) ? pel_q[f][0] : '0;
        end
        out_if.full = full_v;
    endtask

    // ---------------- model: expected words for one S×S block ----------------
    task automatic load_block(input int f, input int s, input logic [DW-1:0] pix[$]);
        ext_q[f].push_back(EW'(s));
        foreach (pix[i]) pend_q[f].push_back(pix[i]);
        for (int r = 0; r < s; r++) begin
            for (int b = 0; b < BORDER; b++) exp_q[f].push_back(ZP ? '0 : pix[r*s]);
            for (int c = 0; c < s; c++)      exp_q[f].push_back(pix[r*s + c]);
            for (int b = 0; b < BORDER; b++) exp_q[f].push_back(ZP ? '0 : pix[r*s + s - 1]);
        end
    endtask

    function automatic bit all_drained();
        for (int f = 0; f < FLUX; f++) begin
            if (exp_q[f].size() != 0 || pend_q[f].size() != 0 ||
                pel_q[f].size() != 0 || ext_q[f].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while (!all_drained() && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!all_drained()) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles without drain, expected drain within %0d", name, n, max_cyc);
        end
        sync();
    endtask

    task automatic clear_logs();
        for (int f = 0; f < FLUX; f++) out_log[f].delete();
        tag_log.delete();
        first_wr_cyc = -1;
        ext_rd_cyc   = -1;
    endtask

    // ---------------- FIFO engine + compare process ----------------
    initial begin
        drive_fifos();
        forever begin
            @(negedge clk);
            neg_cyc++;
            s_rd_ext = ext_if.read;
            s_rd_pel = pel_if.read;
            s_wr     = out_if.write;
            s_din    = out_if.din;
            if (!rst) begin
                for (int f = 0; f < FLUX; f++) begin
                    if (s_rd_ext[f]) chk("ext_read_nonempty", int'(ext_q[f].size() != 0), 1);
                    if (s_rd_pel[f]) chk("pel_read_nonempty", int'(pel_q[f].size() != 0), 1);
                end
                if (s_rd_ext[0] && ext_rd_cyc < 0) ext_rd_cyc = neg_cyc;
                if (s_wr) begin
                    int          tg;
                    logic [DW-1:0] px;
                    tg = int'(s_din[TW+DW-1:DW]);
                    px = s_din[DW-1:0];
                    chk("write_while_full", int'(out_if.full[tg]), 0);
                    tag_log.push_back(tg);
                    out_log[tg].push_back(px);
                    if (tg == 0 && first_wr_cyc < 0) first_wr_cyc = neg_cyc;
                    checks++;
                    if (exp_q[tg].size() == 0) begin
                        errors++;
                        $display("FAIL pixel_unexpected: flux %0d got %0d expected no word", tg, px);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q[tg].pop_front();
                        if (px !== e) begin
                            errors++;
                            $display("FAIL pixel: flux %0d got %0d expected %0d", tg, px, e);
                        end
                    end
                end
            end
            @(posedge clk);
            rst_edge = rst;
            #1;
            if (!rst_edge) begin
                for (int f = 0; f < FLUX; f++) begin
                    if (s_rd_ext[f] && ext_q[f].size() != 0) void'(ext_q[f].pop_front());
                    if (s_rd_pel[f] && pel_q[f].size() != 0) void'(pel_q[f].pop_front());
                end
            end
            for (int f = 0; f < FLUX; f++) begin
                if (!trickle) begin
                    while (pend_q[f].size() != 0) pel_q[f].push_back(pend_q[f].pop_front());
                end else if (pend_q[f].size() != 0 && $urandom_range(0, 1) == 1) begin
                    pel_q[f].push_back(pend_q[f].pop_front());
                end
                if (full_rand) full_v[f] = ($urandom_range(0, 3) == 0);
            end
            drive_fifos();
        end
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- directed + random tests ----------------
    initial begin
        logic [DW-1:0] pix[$];
        logic [DW-1:0] lit_row[12];
        logic [DW-1:0] lit_s1[5];
        int            n, n0;

        if (ZP) begin
            lit_row = '{0, 0, 10, 11, 0, 0, 0, 0, 20, 21, 0, 0};
            lit_s1  = '{0, 0, 1, 0, 0};
        end else begin
            lit_row = '{10, 10, 10, 11, 11, 11, 20, 20, 20, 21, 21, 21};
            lit_s1  = '{1, 1, 1, 1, 1};
        end

        // Reset state: outputs gated, contexts idle, even with a size queued.
        repeat (2) sync();
        ext_q[0].push_back(7'd1);
        sync();
        chk("rst_ext_read", int'(ext_if.read), 0);
        chk("rst_write", int'(out_if.write), 0);
        chk("rst_state0", int'(dbg_state[0]), int'(IDLE));
        chk("rst_state1", int'(dbg_state[1]), int'(IDLE));
        ext_q[0].delete();
        sync();
        rst = 1'b0;
        sync();

        // T1: S=2 block on flux0, plus size-to-first-word latency.
        clear_logs();
        pix = '{10, 11, 20, 21};
        load_block(0, 2, pix);
        wait_drain("t1", 200);
        chk("t1_latency", first_wr_cyc - ext_rd_cyc, 1);
        chk("t1_len", out_log[0].size(), 12);
        for (int i = 0; i < 12 && i < out_log[0].size(); i++) chk("t1_word", int'(out_log[0][i]), int'(lit_row[i]));
        chk("t1_tag1_words", out_log[1].size(), 0);
        chk("t1_idle", int'(dbg_state[0]), int'(IDLE));

        // T2: same block with a 3-cycle stall mid-row.
        clear_logs();
        load_block(0, 2, pix);
        n = 0;
        while (out_log[0].size() < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        full_v[0] = 1'b1;
        sync();
        n0 = out_log[0].size();
        repeat (2) sync();
        chk("t2_stall_frozen", out_log[0].size(), n0);
        full_v[0] = 1'b0;
        wait_drain("t2", 200);
        chk("t2_len", out_log[0].size(), 12);
        for (int i = 0; i < 12 && i < out_log[0].size(); i++) chk("t2_word", int'(out_log[0][i]), int'(lit_row[i]));

        // T3: both fluxes S=1; flux0 has priority so its row comes out whole first.
        clear_logs();
        pix = '{5};
        load_block(0, 1, pix);
        pix = '{7};
        load_block(1, 1, pix);
        wait_drain("t3", 200);
        chk("t3_len", tag_log.size(), 10);
        for (int i = 0; i < 10 && i < tag_log.size(); i++) chk("t3_tag", tag_log[i], (i < 5) ? 0 : 1);
        chk("t3_f0_mid", (out_log[0].size() > 2) ? int'(out_log[0][2]) : -1, 5);
        chk("t3_f1_edge", (out_log[1].size() > 0) ? int'(out_log[1][0]) : -1, ZP ? 0 : 7);

        // T4: zero size is swallowed, then S=1 block.
        clear_logs();
        pix.delete();
        load_block(0, 0, pix);
        pix = '{1};
        load_block(0, 1, pix);
        wait_drain("t4", 200);
        chk("t4_len", out_log[0].size(), 5);
        for (int i = 0; i < 5 && i < out_log[0].size(); i++) chk("t4_word", int'(out_log[0][i]), int'(lit_s1[i]));

        // T5: asynchronous reset while flux0 is in MID.
        clear_logs();
        pix.delete();
        for (int i = 0; i < 9; i++) pix.push_back(DW'(100 + i));
        load_block(0, 3, pix);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (dbg_state[0] != MID && n < 200);
        chk("t5_in_mid", int'(dbg_state[0]), int'(MID));
        chk("t5_write_before", int'(out_if.write), 1);
        rst = 1'b1;
        #1;
        chk("t5_write_drop", int'(out_if.write), 0);
        chk("t5_read_drop", int'(pel_if.read), 0);
        chk("t5_state_reset", int'(dbg_state[0]), int'(IDLE));
        sync();
        for (int f = 0; f < FLUX; f++) begin
            ext_q[f].delete();
            pel_q[f].delete();
            pend_q[f].delete();
            exp_q[f].delete();
        end
        repeat (2) sync();
        rst = 1'b0;
        sync();
        clear_logs();
        pix = '{1};
        load_block(0, 1, pix);
        wait_drain("t5", 200);
        chk("t5_len", out_log[0].size(), 5);
        for (int i = 0; i < 5 && i < out_log[0].size(); i++) chk("t5_word", int'(out_log[0][i]), int'(lit_s1[i]));

        // T6: random blocks on both fluxes with starvation and backpressure.
        trickle   = 1'b1;
        full_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int f, s;
            f = $urandom_range(0, FLUX - 1);
            s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            pix.delete();
            for (int i = 0; i < s * s; i++) pix.push_back(DW'($urandom));
            load_block(f, s, pix);
            repeat ($urandom_range(0, 20)) sync();
        end
        wait_drain("t6", 20000);
        trickle   = 1'b0;
        full_rand = 1'b0;
        full_v    = '0;
        repeat (2) sync();
        chk("t6_idle0", int'(dbg_state[0]), int'(IDLE));
        chk("t6_idle1", int'(dbg_state[1]), int'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
